tt_io_hub: RTL



---
 rtl/tt_io_pkg.sv | 26 ++
 rtl/tt_debounce.sv | 60 ++++++
 rtl/tt_io_hub.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tt_io_pkg.sv
// tt_io_pkg: shared definitions for the tt_io_hub tile.
//   addr_e   - command register addresses, selected by debounced ui_in[2:1]
//   mode_e   - io_uo_out source selection held in the MODE register
//   *_RST    - register values after reset
package tt_io_pkg;

    typedef enum logic [1:0] {
        ADDR_MODE  = 2'd0,
        ADDR_OE    = 2'd1,
        ADDR_OUT   = 2'd2,
        ADDR_PRESC = 2'd3
    } addr_e;

    typedef enum logic [1:0] {
        MODE_INPUTS  = 2'd0,
        MODE_COUNTER = 2'd1,
        MODE_EDGES   = 2'd2,
        MODE_LOOP    = 2'd3
    } mode_e;

    localparam mode_e      MODE_RST  = MODE_INPUTS;
    localparam logic [7:0] OE_RST    = 8'h00;
    localparam logic [7:0] OUT_RST   = 8'h00;
    localparam logic [7:0] PRESC_RST = 8'h00;

endpackage

// File: rtl/tt_debounce.sv
// tt_debounce: per-bit synchroniser followed by a tick-sampled debouncer.
//   clock, reset  - system clock, synchronous active-high reset
//   din[WIDTH]    - asynchronous inputs
//   dout[WIDTH]   - channels below DEB_CH debounced, the rest synchronised only
// A shared counter produces one sample tick every 2^DEBOUNCE_BITS clocks; a
// channel's output only follows its input once two consecutive ticks agree.
module tt_debounce #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEB_CH        = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DEBOUNCE_BITS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [DEBOUNCE_BITS-1:0]          tick_cnt_q, tick_cnt_d;
    logic [DEB_CH-1:0]                 samp_q, samp_d;
    logic [DEB_CH-1:0]                 deb_q, deb_d;
    logic [WIDTH-1:0]                  s;
    logic [DEB_CH-1:0]                 s_lo;
    logic [DEB_CH-1:0]                 stable;
    logic                              tick;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], din};
        s          = sync_q[SYNC_STAGES-1];
        tick_cnt_d = tick_cnt_q + 1'b1;
        // Counter reaches all-ones on the 2^N-th clock after reset release.
        tick       = &tick_cnt_q;
        s_lo       = s[DEB_CH-1:0];
        stable     = ~(s_lo ^ samp_q);
        samp_d     = samp_q;
        deb_d      = deb_q;
        if (tick) begin
            samp_d = s_lo;
            deb_d  = (s_lo & stable) | (deb_q & ~stable);
        end
        dout             = s;
        dout[DEB_CH-1:0] = deb_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q     <= '0;
            tick_cnt_q <= '0;
            samp_q     <= '0;
            deb_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            tick_cnt_q <= tick_cnt_d;
            samp_q     <= samp_d;
            deb_q      <= deb_d;
        end
    end

endmodule

// File: rtl/tt_io_hub.sv
// tt_io_hub: tile top with debounced inputs, a 4-register command interface,
// a prescaled free-running counter, an edge counter and a selectable output.
//   clock, reset  - system clock, synchronous active-high reset
//   io_ui_in      - [0] strobe, [2:1] register address, [7] edge-count source
//   io_uo_out     - registered output, source chosen by MODE
//   io_uio_in     - write data for register commands
//   io_uio_out    - OUT register
//   io_uio_oe     - OE register (1 = drive)
module tt_io_hub
    import tt_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DEBOUNCE_BITS = 16,
    parameter int unsigned NUM_CH        = 8,
    parameter int unsigned CNT_WIDTH     = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] io_ui_in,
    output logic [7:0] io_uo_out,
    input  logic [7:0] io_uio_in,
    output logic [7:0] io_uio_out,
    output logic [7:0] io_uio_oe
);

    logic [7:0]           deb;
    mode_e                mode_q, mode_d;
    logic [7:0]           oe_q, oe_d;
    logic [7:0]           out_q, out_d;
    logic [7:0]           presc_q, presc_d;
    logic [7:0]           pcnt_q, pcnt_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]           edge_cnt_q, edge_cnt_d;
    logic                 strobe_prev_q, strobe_prev_d;
    logic                 edge_prev_q, edge_prev_d;
    logic [7:0]           uo_q, uo_d;
    logic                 wr;
    addr_e                addr;

    tt_debounce #(
        .WIDTH         (8),
        .DEB_CH        (NUM_CH),
        .SYNC_STAGES   (SYNC_STAGES),
        .DEBOUNCE_BITS (DEBOUNCE_BITS)
    ) u_debounce (
        .clock (clock),
        .reset (reset),
        .din   (io_ui_in),
        .dout  (deb)
    );

    always_comb begin
        mode_d        = mode_q;
        oe_d          = oe_q;
        out_d         = out_q;
        presc_d       = presc_q;
        edge_cnt_d    = edge_cnt_q;
        cnt_d         = cnt_q;
        strobe_prev_d = deb[0];
        edge_prev_d   = deb[7];
        addr          = addr_e'(deb[2:1]);
        wr            = deb[0] & ~strobe_prev_q;

        if (wr) begin
            case (addr)
                ADDR_MODE:  mode_d  = mode_e'(io_uio_in[1:0]);
                ADDR_OE:    oe_d    = io_uio_in;
                ADDR_OUT:   out_d   = io_uio_in;
                ADDR_PRESC: presc_d = io_uio_in;
                default:    ;
            endcase
        end

        if (pcnt_q == presc_q) begin
            pcnt_d = '0;
            cnt_d  = cnt_q + 1'b1;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end
        // A PRESC write restarts the prescale count but leaves any
        // counter increment already due this cycle in place.
        if (wr && addr == ADDR_PRESC) begin
            pcnt_d = '0;
        end

        if (deb[7] && !edge_prev_q) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
        end

        uo_d = '0;
        case (mode_q)
            MODE_INPUTS:  uo_d = deb;
            MODE_COUNTER: uo_d = cnt_q[CNT_WIDTH-1 -: 8];
            MODE_EDGES:   uo_d = edge_cnt_q;
            MODE_LOOP:    uo_d = out_q;
            default:      uo_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q        <= MODE_RST;
            oe_q          <= OE_RST;
            out_q         <= OUT_RST;
            presc_q       <= PRESC_RST;
            pcnt_q        <= '0;
            cnt_q         <= '0;
            edge_cnt_q    <= '0;
            strobe_prev_q <= 1'b0;
            edge_prev_q   <= 1'b0;
            uo_q          <= '0;
        end else begin
            mode_q        <= mode_d;
            oe_q          <= oe_d;
            out_q         <= out_d;
            presc_q       <= presc_d;
            pcnt_q        <= pcnt_d;
            cnt_q         <= cnt_d;
            edge_cnt_q    <= edge_cnt_d;
            strobe_prev_q <= strobe_prev_d;
            edge_prev_q   <= edge_prev_d;
            uo_q          <= uo_d;
        end
    end

    assign io_uo_out  = uo_q;
    assign io_uio_out = out_q;
    assign io_uio_oe  = oe_q;

endmodule
